branch_sequencer: RTL

- Instruction-sequencing controller that owns the current instruction address (CIA) and steps each instruction through fetch, response and execute.
- Presents each fetched instruction to the branch facility for a one-cycle evaluation. Applies the resulting next-instruction address and the LR/CTR side effects.
- Hands non-branch instructions to the execution pipe and waits for completion. Sits between the instruction-memory port, the branch facility and the LR/CTR registers.
- Exactly one instruction is in flight at a time.

---
 rtl/branch_sequencer_if.sv | 58 +++++
 rtl/branch_sequencer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/branch_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_sequencer_if
//  Description : Bundles every non-clock/reset signal of branch_sequencer.
//                It covers the fetch port, the branch facility, LR/CTR, the
//                execution pipe, redirect and status. The master side is the
//                sequencer and the slave side is its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface branch_sequencer_if;
    logic        i_run;
    logic        i_32b_mode;
    logic        o_fetch_valid;
    logic        i_fetch_ready;
    logic [63:0] o_fetch_addr;
    logic        i_resp_valid;
    logic [31:0] i_resp_instr;
    logic        o_bf_en;
    logic [31:0] o_bf_instr;
    logic [63:0] o_bf_cia;
    logic        i_bf_is_branch;
    logic        i_bf_taken;
    logic [63:0] i_bf_target;
    logic        i_bf_ctr_dec;
    logic        i_bf_lk;
    logic [63:0] i_ctr;
    logic        o_lr_we;
    logic [63:0] o_lr_wdata;
    logic        o_ctr_we;
    logic [63:0] o_ctr_wdata;
    logic        o_exec_valid;
    logic        i_exec_done;
    logic        i_redirect_valid;
    logic [63:0] i_redirect_addr;
    logic [63:0] o_cia;
    logic        o_retire;
    logic [63:0] o_retire_count;
    logic        o_halted;

    modport master (
        input  i_run, i_32b_mode, i_fetch_ready, i_resp_valid, i_resp_instr,
               i_bf_is_branch, i_bf_taken, i_bf_target, i_bf_ctr_dec, i_bf_lk,
               i_ctr, i_exec_done, i_redirect_valid, i_redirect_addr,
        output o_fetch_valid, o_fetch_addr, o_bf_en, o_bf_instr, o_bf_cia,
               o_lr_we, o_lr_wdata, o_ctr_we, o_ctr_wdata, o_exec_valid,
               o_cia, o_retire, o_retire_count, o_halted
    );

    modport slave (
        output i_run, i_32b_mode, i_fetch_ready, i_resp_valid, i_resp_instr,
               i_bf_is_branch, i_bf_taken, i_bf_target, i_bf_ctr_dec, i_bf_lk,
               i_ctr, i_exec_done, i_redirect_valid, i_redirect_addr,
        input  o_fetch_valid, o_fetch_addr, o_bf_en, o_bf_instr, o_bf_cia,
               o_lr_we, o_lr_wdata, o_ctr_we, o_ctr_wdata, o_exec_valid,
               o_cia, o_retire, o_retire_count, o_halted
    );
endinterface
`default_nettype wire

// File: rtl/branch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : branch_sequencer
//  Description : Single-issue instruction sequencer. It owns the CIA and steps
//                each instruction through fetch, response and execute. It
//                applies branch-facility results (NIA, LR, CTR) and hands
//                non-branch instructions to the execution pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_sequencer #(
    parameter logic [63:0] RESET_VECTOR = 64'h0000_0000_0000_0100
) (
    input  wire logic            i_clk,
    input  wire logic            i_rst,
    branch_sequencer_if.master   bus
);

    localparam logic [63:0] c_lo32_mask = 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] c_all_ones  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] c_word_mask = 64'hFFFF_FFFF_FFFF_FFFC;

    typedef enum logic [2:0] {
        ST_HALT      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_WAIT      = 3'd2,
        ST_EXEC      = 3'd3,
        ST_EXEC_WAIT = 3'd4
    } state_t;

    state_t      r_state;
    logic [63:0] r_cia;
    logic [63:0] r_retire_count;
    logic [31:0] r_instr;
    logic        r_drop;

    logic [63:0] w_mode_mask;
    logic [63:0] w_cia_m;
    logic [63:0] w_seq_nia;
    logic [63:0] w_target;
    logic [63:0] w_redir;
    logic [63:0] w_exec_nia;
    logic        w_redirect;
    logic        w_br_fire;
    logic        w_complete;
    logic        w_next_fetch;

    // In 32-bit mode every address leaving or entering the CIA loses [63:32]
    assign w_mode_mask = bus.i_32b_mode ? c_lo32_mask : c_all_ones;
    assign w_cia_m     = r_cia & w_mode_mask;
    assign w_seq_nia   = (r_cia + 64'd4) & w_mode_mask;
    assign w_target    = bus.i_bf_target & c_word_mask & w_mode_mask;
    assign w_redir     = bus.i_redirect_addr & w_mode_mask;
    assign w_redirect  = bus.i_redirect_valid;

    // Branch results only count in the evaluation cycle and lose to a redirect
    assign w_br_fire   = (r_state == ST_EXEC) && bus.i_bf_is_branch && !w_redirect;
    assign w_complete  = !w_redirect &&
                         (((r_state == ST_EXEC) && (bus.i_bf_is_branch || bus.i_exec_done)) ||
                          ((r_state == ST_EXEC_WAIT) && bus.i_exec_done));
    assign w_exec_nia  = (w_br_fire && bus.i_bf_taken) ? w_target : w_seq_nia;
    assign w_next_fetch = bus.i_run;

    assign bus.o_fetch_valid  = (r_state == ST_FETCH) && !w_redirect;
    assign bus.o_fetch_addr   = w_cia_m;
    assign bus.o_bf_en        = (r_state == ST_EXEC);
    assign bus.o_bf_instr     = r_instr;
    assign bus.o_bf_cia       = w_cia_m;
    assign bus.o_lr_we        = w_br_fire && bus.i_bf_lk;
    assign bus.o_lr_wdata     = w_seq_nia;
    assign bus.o_ctr_we       = w_br_fire && bus.i_bf_ctr_dec;
    assign bus.o_ctr_wdata    = bus.i_ctr - 64'd1;
    assign bus.o_exec_valid   = !w_redirect &&
                                (((r_state == ST_EXEC) && !bus.i_bf_is_branch) ||
                                 (r_state == ST_EXEC_WAIT));
    assign bus.o_cia          = w_cia_m;
    assign bus.o_retire       = w_complete;
    assign bus.o_retire_count = r_retire_count;
    assign bus.o_halted       = (r_state == ST_HALT);

    // Sequencing FSM: state, CIA, drop flag, latched instruction and retire count
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state        <= ST_HALT;
            r_cia          <= RESET_VECTOR;
            r_retire_count <= 64'd0;
            r_instr        <= 32'd0;
            r_drop         <= 1'b0;
        end else begin
            case (r_state)
                ST_HALT: begin
                    if (w_redirect) begin
                        r_cia <= w_redir;
                    end else if (bus.i_run) begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (w_redirect) begin
                        r_cia <= w_redir;
                    end else if (bus.i_fetch_ready) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_redirect) begin
                        r_cia <= w_redir;
                    end
                    // A response belonging to a redirected-away fetch is thrown away
                    if (bus.i_resp_valid) begin
                        if (r_drop || w_redirect) begin
                            r_drop  <= 1'b0;
                            r_state <= ST_FETCH;
                        end else begin
                            r_instr <= bus.i_resp_instr;
                            r_state <= ST_EXEC;
                        end
                    end else if (w_redirect) begin
                        r_drop <= 1'b1;
                    end
                end
                ST_EXEC, ST_EXEC_WAIT: begin
                    if (w_redirect) begin
                        r_cia   <= w_redir;
                        r_state <= w_next_fetch ? ST_FETCH : ST_HALT;
                    end else if (w_complete) begin
                        r_cia          <= w_exec_nia;
                        r_retire_count <= r_retire_count + 64'd1;
                        r_state        <= w_next_fetch ? ST_FETCH : ST_HALT;
                    end else begin
                        r_state <= ST_EXEC_WAIT;
                    end
                end
                default: begin
                    r_state <= ST_HALT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
